sobel_window_gen: RTL and testbench
===================================

// Module: sobel_window_gen
// PURPOSE
//  Producer side of the 3x3 window interface consumed by the Sobel edge stage.
//  Accepts a raster-order 8-bit luma stream, buffers two prior lines, and emits
//  z0..z8 every accepted pixel once a full 3x3 neighbourhood exists.
//  Layout: z0 z1 z2 = oldest line, z3 z4 z5 = middle, z6 z7 z8 = newest line;
//  z2/z5/z8 = newest column (right), z0/z3/z6 = oldest column (left).
// PARAMETERS
//  IMG_WIDTH  640  active pixels per line (>= 3)
//  COL_W      10   column counter width, 2**COL_W >= IMG_WIDTH
//  ROW_W      10   row counter width
// PORTS
//  clock        in   1      single system clock, all logic rising-edge
//  reset        in   1      asynchronous, active-high; clears all state
//  pix_in       in   8      incoming pixel
//  pix_valid    in   1      pix_in accepted this cycle (no backpressure)
//  frame_start  in   1      first pixel of frame; restarts counters
//  z0..z8       out  8 ea   window pixels, registered
//  win_valid    out  1      z0..z8 hold a complete window this cycle
//  win_x        out  COL_W  window centre column (SOBEL_WIN_COORD_EN only)
//  win_y        out  ROW_W  window centre row    (SOBEL_WIN_COORD_EN only)
// BEHAVIOUR
//  - Reset: z0..z8=0, win_valid=0, win_x=win_y=0, col=row=0. Line-buffer RAM
//    contents not cleared (masked by row gating below).
//  - Accept on pix_valid=1: read lb1[col], lb2[col] (read-before-write);
//    write lb2[col]<=lb1[col], lb1[col]<=pix_in. Shift window left:
//    {z0,z1}<={z1,z2}, {z3,z4}<={z4,z5}, {z6,z7}<={z7,z8};
//    z2<=lb2[col], z5<=lb1[col], z8<=pix_in.
//  - Latency: window and win_valid update 1 cycle after accepting edge.
//  - win_valid<=1 on accept iff row>=2 and col>=2 (at accepted pixel); else 0.
//    Cleared on any cycle with pix_valid=0 (one pulse per accepted pixel).
//  - Coordinates: win_x<=col-1, win_y<=row-1 of the accepted pixel.
//  - Column wrap: col==IMG_WIDTH-1 -> col<=0, row<=row+1; row saturates at
//    2**ROW_W-1 (no wrap). Window columns are NOT flushed at line wrap; the
//    col>=2 gate suppresses cross-line windows.
//  - frame_start&pix_valid: pixel treated as (0,0); after it col=1, row=0.
//  - frame_start without pix_valid: col=row=0, win_valid<=0; next accepted
//    pixel is (0,0).
//  - Reset mid-line: all counters/outputs to reset values immediately; first
//    post-reset pixel is (0,0) whether or not frame_start accompanies it.
//  - Pixel arithmetic: none; pure 8-bit transport.
// CONFIGURATION
//  SOBEL_WIN_COORD_EN defined: win_x/win_y ports and counters-to-output regs
//  present. Undefined: ports absent, win_valid/z timing identical.
// STRUCTURE
//  Package sobel_win_pkg: PIX_W=8, typedef logic [7:0] pix_t, default
//  IMG_WIDTH/COL_W/ROW_W localparams shared with sobel stage.
//  Sub-module sobel_line_buf: IMG_WIDTH x 8 RAM, one address, read-before-
//  write, synchronous write; instantiated twice (lb1, lb2).
// TESTING
//  1 IMG_WIDTH=8, reset, frame_start, pixels p=row*8+col -> first win_valid
//    after pixel (2,2): z0..z8 = 0,1,2,8,9,10,16,17,18, win_x=1,win_y=1.
//  2 Continue row 2 -> exactly 6 win_valid pulses per row; none for col 0,1.
//  3 Line wrap at col 7->0 -> no win_valid for pixel (0,3),(1,3); (2,3) window
//    = 8,9,10,16,17,18,24,25,26.
//  4 Gaps: pix_valid toggled 1/0 randomly -> windows identical to gapless
//    run; win_valid=0 on every idle cycle.
//  5 Assert reset at pixel (4,3) -> outputs 0 next edge asynchronously; then
//    new frame -> first win_valid at (2,2) with fresh data only.
//  6 frame_start mid-frame at (5,4) -> counters restart, that pixel is (0,0),
//    no win_valid until new-frame (2,2).

Source files
------------

// File: rtl/sobel_win_pkg.sv
// Shared types and default geometry for the Sobel window producer and the edge stage.
// Optional coordinate outputs are enabled by defining SOBEL_WIN_COORD_EN.
package sobel_win_pkg;
  localparam int PIX_W         = 8;
  localparam int IMG_WIDTH_DEF = 640;
  localparam int COL_W_DEF     = 10;
  localparam int ROW_W_DEF     = 10;

  typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/sobel_line_buf.sv
// One-line pixel store: single address, asynchronous read, synchronous write.
// A read and a write at the same address return the old contents.
module sobel_line_buf
  import sobel_win_pkg::*;
#(
  parameter int DEPTH  = IMG_WIDTH_DEF,
  parameter int ADDR_W = COL_W_DEF
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  pix_t              wdata,
  output pix_t              rdata
);

  pix_t mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 window generator: two line buffers plus a 3-column shift window over a raster stream.
// Define SOBEL_WIN_COORD_EN to add the win_x/win_y window-centre outputs.
module sobel_window_gen
  import sobel_win_pkg::*;
#(
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int COL_W     = COL_W_DEF,
  parameter int ROW_W     = ROW_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  pix_t             pix_in,
  input  logic             pix_valid,
  input  logic             frame_start,
  output pix_t             z0,
  output pix_t             z1,
  output pix_t             z2,
  output pix_t             z3,
  output pix_t             z4,
  output pix_t             z5,
  output pix_t             z6,
  output pix_t             z7,
  output pix_t             z8,
  output logic             win_valid
`ifdef SOBEL_WIN_COORD_EN
  ,
  output logic [COL_W-1:0] win_x,
  output logic [ROW_W-1:0] win_y
`endif
);

  // Handshake: a pixel is consumed on every rising edge with pix_valid=1 (no
  // backpressure); win_valid is a one-cycle pulse qualifying z0..z8 in the
  // cycle after the accepting edge and is never held across idle cycles.

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] eff_col;
  logic [ROW_W-1:0] eff_row;
  pix_t             lb1_rd;
  pix_t             lb2_rd;
  logic             win_ok;

  // frame_start re-labels the current pixel as (0,0) of a new frame.
  always_comb begin
    eff_col = col;
    eff_row = row;
    if (frame_start) begin
      eff_col = '0;
      eff_row = '0;
    end
  end

  assign win_ok = (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);

  sobel_line_buf #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb1 (
    .clock (clock),
    .we    (pix_valid),
    .addr  (eff_col),
    .wdata (pix_in),
    .rdata (lb1_rd)
  );

  sobel_line_buf #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb2 (
    .clock (clock),
    .we    (pix_valid),
    .addr  (eff_col),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      {z0, z1, z2, z3, z4, z5, z6, z7, z8} <= '0;
    end else begin
      win_valid <= 1'b0;
      if (pix_valid) begin
        {z0, z1} <= {z1, z2};
        {z3, z4} <= {z4, z5};
        {z6, z7} <= {z7, z8};
        z2        <= lb2_rd;
        z5        <= lb1_rd;
        z8        <= pix_in;
        win_valid <= win_ok;
        if (eff_col == LAST_COL) begin
          col <= '0;
          // Row saturates so a runaway stream never wraps back into row gating.
          row <= (eff_row == '1) ? eff_row : eff_row + ROW_W'(1);
        end else begin
          col <= eff_col + COL_W'(1);
          row <= eff_row;
        end
      end else if (frame_start) begin
        col <= '0;
        row <= '0;
      end
    end
  end

`ifdef SOBEL_WIN_COORD_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_x <= '0;
      win_y <= '0;
    end else if (pix_valid) begin
      win_x <= eff_col - COL_W'(1);
      win_y <= eff_row - ROW_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on an 8-pixel-wide image; pixel value = offset + row*8 + col.
// Coordinate checks are compiled in when SOBEL_WIN_COORD_EN is defined.
module tb_sobel_window_gen;

  localparam int W = 8;

  logic       clock;
  logic       reset;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       frame_start;
  logic [7:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
  logic       win_valid;
`ifdef SOBEL_WIN_COORD_EN
  logic [3:0] win_x;
  logic [3:0] win_y;
`endif
  logic [7:0] zs [9];

  int n_cmp = 0;
  int n_err = 0;

  sobel_window_gen #(.IMG_WIDTH(W), .COL_W(4), .ROW_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .z0          (z0),
    .z1          (z1),
    .z2          (z2),
    .z3          (z3),
    .z4          (z4),
    .z5          (z5),
    .z6          (z6),
    .z7          (z7),
    .z8          (z8),
    .win_valid   (win_valid)
`ifdef SOBEL_WIN_COORD_EN
    ,
    .win_x       (win_x),
    .win_y       (win_y)
`endif
  );

  assign zs[0] = z0;
  assign zs[1] = z1;
  assign zs[2] = z2;
  assign zs[3] = z3;
  assign zs[4] = z4;
  assign zs[5] = z5;
  assign zs[6] = z6;
  assign zs[7] = z7;
  assign zs[8] = z8;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // expected window element k for a window centred one left/up of pixel (c,r)
  function automatic logic [7:0] exp_z(input int o, input int c, input int r, input int k);
    return 8'(o + (r - 2 + k / 3) * W + (c - 2 + k % 3));
  endfunction

  // driver: present one cycle of input at negedge, sample #1 after the accepting edge
  task automatic drive(input logic [7:0] p, input logic v, input logic fs);
    @(negedge clock);
    pix_in      = p;
    pix_valid   = v;
    frame_start = fs;
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input int o, input int c, input int r, input logic fs);
    drive(8'(o + r * W + c), 1'b1, fs);
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_in = '0; pix_valid = 1'b0; frame_start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (win_valid !== 1'b0) begin n_err++; $display("FAIL reset_win_valid got %0b want 0", win_valid); end
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (zs[k] !== 8'd0) begin n_err++; $display("FAIL reset_z%0d got %0d want 0", k, zs[k]); end
    end
`ifdef SOBEL_WIN_COORD_EN
    n_cmp++;
    if (win_x !== 4'd0 || win_y !== 4'd0) begin
      n_err++; $display("FAIL reset_coord got %0d,%0d want 0,0", win_x, win_y);
    end
`endif
    @(negedge clock);
    reset = 1'b0;
  endtask

  // rows 0..2 of frame offset 0; first window at (2,2), six pulses in row 2
  task automatic test_first_window();
    int pulses;
    pulses = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        feed(0, c, r, (r == 0 && c == 0));
        n_cmp++;
        if (win_valid !== ((r >= 2 && c >= 2) ? 1'b1 : 1'b0)) begin
          n_err++; $display("FAIL first_valid at (%0d,%0d) got %0b", c, r, win_valid);
        end
        if (r == 2 && win_valid === 1'b1) pulses++;
        if (r == 2 && c == 2) begin
          for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (zs[k] !== exp_z(0, c, r, k)) begin
              n_err++; $display("FAIL first_z%0d got %0d want %0d", k, zs[k], exp_z(0, c, r, k));
            end
          end
`ifdef SOBEL_WIN_COORD_EN
          n_cmp++;
          if (win_x !== 4'd1 || win_y !== 4'd1) begin
            n_err++; $display("FAIL first_coord got %0d,%0d want 1,1", win_x, win_y);
          end
`endif
        end
      end
    end
    n_cmp++;
    if (pulses != 6) begin n_err++; $display("FAIL row2_pulses got %0d want 6", pulses); end
  endtask

  // row 3 cols 0..2: no cross-line window, then window 8..26 at (2,3)
  task automatic test_line_wrap();
    for (int c = 0; c < 3; c++) begin
      feed(0, c, 3, 1'b0);
      n_cmp++;
      if (win_valid !== ((c >= 2) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL wrap_valid at (%0d,3) got %0b", c, win_valid);
      end
    end
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (zs[k] !== exp_z(0, 2, 3, k)) begin
        n_err++; $display("FAIL wrap_z%0d got %0d want %0d", k, zs[k], exp_z(0, 2, 3, k));
      end
    end
  endtask

  // reset asserted after (4,3), then a new frame without frame_start
  task automatic test_reset_mid_line();
    feed(0, 3, 3, 1'b0);
    feed(0, 4, 3, 1'b0);
    n_cmp++;
    if (win_valid !== 1'b1 || z8 !== 8'd28) begin
      n_err++; $display("FAIL pre_reset got valid=%0b z8=%0d want 1,28", win_valid, z8);
    end
    #2;
    reset = 1'b1; pix_valid = 1'b0;
    #1;
    n_cmp++;
    if (win_valid !== 1'b0 || z8 !== 8'd0 || z4 !== 8'd0) begin
      n_err++; $display("FAIL async_reset got valid=%0b z4=%0d z8=%0d want 0,0,0", win_valid, z4, z8);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c > 2) break;
        feed(100, c, r, 1'b0);
        n_cmp++;
        if (win_valid !== ((r == 2 && c == 2) ? 1'b1 : 1'b0)) begin
          n_err++; $display("FAIL post_reset_valid at (%0d,%0d) got %0b", c, r, win_valid);
        end
      end
    end
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (zs[k] !== exp_z(100, 2, 2, k)) begin
        n_err++; $display("FAIL post_reset_z%0d got %0d want %0d", k, zs[k], exp_z(100, 2, 2, k));
      end
    end
  endtask

  // rest of row 2, row 3 and row 4 up to col 4 with random idle gaps
  task automatic test_gaps();
    int r, c;
    r = 2; c = 3;
    while (!(r == 4 && c == 5)) begin
      repeat ($urandom_range(0, 2)) begin
        drive(8'hee, 1'b0, 1'b0);
        n_cmp++;
        if (win_valid !== 1'b0) begin n_err++; $display("FAIL gap_idle_valid got %0b want 0", win_valid); end
      end
      feed(100, c, r, 1'b0);
      n_cmp++;
      if (win_valid !== ((c >= 2) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL gap_valid at (%0d,%0d) got %0b", c, r, win_valid);
      end
      if (c >= 2) begin
        for (int k = 0; k < 9; k++) begin
          n_cmp++;
          if (zs[k] !== exp_z(100, c, r, k)) begin
            n_err++; $display("FAIL gap_z%0d at (%0d,%0d) got %0d want %0d", k, c, r, zs[k], exp_z(100, c, r, k));
          end
        end
      end
      c++;
      if (c == W) begin c = 0; r++; end
    end
  endtask

  // frame_start with pixel (5,4): that pixel becomes (0,0) of frame offset 200
  task automatic test_frame_start_mid();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c > 2) break;
        feed(200, c, r, (r == 0 && c == 0));
        n_cmp++;
        if (win_valid !== ((r == 2 && c == 2) ? 1'b1 : 1'b0)) begin
          n_err++; $display("FAIL fs_mid_valid at (%0d,%0d) got %0b", c, r, win_valid);
        end
      end
    end
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (zs[k] !== exp_z(200, 2, 2, k)) begin
        n_err++; $display("FAIL fs_mid_z%0d got %0d want %0d", k, zs[k], exp_z(200, 2, 2, k));
      end
    end
`ifdef SOBEL_WIN_COORD_EN
    n_cmp++;
    if (win_x !== 4'd1 || win_y !== 4'd1) begin
      n_err++; $display("FAIL fs_mid_coord got %0d,%0d want 1,1", win_x, win_y);
    end
`endif
  endtask

  // frame_start on an idle cycle: next accepted pixel is (0,0)
  task automatic test_frame_start_idle();
    drive(8'hee, 1'b0, 1'b1);
    n_cmp++;
    if (win_valid !== 1'b0) begin n_err++; $display("FAIL fs_idle_valid got %0b want 0", win_valid); end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c > 2) break;
        feed(50, c, r, 1'b0);
        n_cmp++;
        if (win_valid !== ((r == 2 && c == 2) ? 1'b1 : 1'b0)) begin
          n_err++; $display("FAIL fs_idle_frame_valid at (%0d,%0d) got %0b", c, r, win_valid);
        end
      end
    end
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (zs[k] !== exp_z(50, 2, 2, k)) begin
        n_err++; $display("FAIL fs_idle_z%0d got %0d want %0d", k, zs[k], exp_z(50, 2, 2, k));
      end
    end
    drive(8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (win_valid !== 1'b0) begin n_err++; $display("FAIL final_idle_valid got %0b want 0", win_valid); end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_line_wrap();
    test_reset_mid_line();
    test_gaps();
    test_frame_start_mid();
    test_frame_start_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
